fft_frame_responder: RTL and testbench
======================================

FFT_FRAME_RESPONDER -- requirements
Module: fft_frame_responder

Interface
REQ-001 SHALL have parameter LANES, default 16, samples per beat.
REQ-002 SHALL have parameter DW, default 64, bits per sample ({re[63:32], im[31:0]}).
REQ-003 SHALL have parameter NBEATS, default 4096, beats per frame; power of two, 2..65536.
REQ-004 SHALL have CLK, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have START, input, 1, host frame request.
REQ-007 SHALL have D, input, LANES*DW, input beat; lane i = D[i*DW +: DW].
REQ-008 SHALL have DONE, output, 1, registered playback-window flag.
REQ-009 SHALL have Q, output, LANES*DW, registered output beat; same lane packing as D.

Function
REQ-010 SHALL implement FSM IDLE, CAPT, PLAY, TAIL, WAIT; DONE = (state==PLAY), registered.
REQ-011 IDLE: START sampled 1 -> CAPT, wptr=0; else stay.
REQ-012 CAPT: each cycle write D to mem[wptr], wptr+1; the write at wptr==NBEATS-1 -> PLAY, rptr=0.
REQ-013 Beat 0 SHALL be taken in the first CAPT cycle; exactly NBEATS consecutive beats, no gaps or stalls.
REQ-014 PLAY: lasts exactly NBEATS cycles; each cycle read mem[addr(rptr)], rptr+1; rptr==NBEATS-1 -> TAIL.
REQ-015 Q SHALL have 1-cycle read latency: beat k on Q in cycle c(k+1), where c0 = first DONE=1 cycle; beat NBEATS-1 in TAIL.
REQ-016 TAIL -> WAIT -> IDLE unconditionally; START ignored in TAIL/WAIT so restart aligns with host's 2-cycle turnaround.
REQ-017 START SHALL be ignored in CAPT/PLAY; deassertion mid-frame does not abort.
REQ-018 Q SHALL hold last driven value outside PLAY/TAIL read updates.
REQ-019 Back-to-back: START held high -> next CAPT entered on the edge after the first IDLE cycle.
REQ-020 Pointers log2(NBEATS) bits, wrap-free by construction; no arithmetic on sample data.
REQ-021 Memory NBEATS x LANES*DW, one write and one sync read port; write and read never concurrent.
REQ-022 Playback of beat written in the same frame SHALL be exact (bit-identical when BITREV_READ_EN off).

Reset
REQ-023 RST SHALL force state=IDLE, DONE=0, Q=0, wptr=0, rptr=0 on the next edge.
REQ-024 RST mid-CAPT/PLAY SHALL abandon the frame; memory contents not cleared.
REQ-025 RST has priority over START in the same cycle.

Configuration
REQ-026 Macro FFT_FRAME_RESPONDER_BITREV_READ_EN defined: addr(rptr) = bit-reverse of rptr over log2(NBEATS) bits.
REQ-027 Macro undefined: addr(rptr) = rptr (linear playback); timing identical in both builds.

Verification (NBEATS=16, LANES=16 unless noted)
REQ-028 Reset then START=1, D beat k lane i = {k,i} -> DONE high exactly 16 cycles starting cycle after 16th beat; Q beat k in c(k+1), equal to input.
REQ-029 BITREV build, same stimulus -> Q in c(k+1) = input beat bitrev4(k) (c2 shows beat 8, c4 shows beat 12).
REQ-030 START held high two frames -> second CAPT begins 2 cycles after DONE falls; both frames reproduced, no beat lost.
REQ-031 RST pulsed at CAPT beat 7 -> DONE stays 0, Q=0; next START captures a full fresh frame correctly.
REQ-032 START dropped after 1 cycle -> frame still completes: 16 DONE cycles, correct Q.
REQ-033 NBEATS=4096 with 65536-sample file -> host capture file equals input file (linear build).

Source files
------------

// File: rtl/fft_frame_responder.sv
// fft_frame_responder: captures one frame of NBEATS consecutive beats into an
// on-chip buffer, then plays it back with DONE marking the playback window.
// Optional build macro FFT_FRAME_RESPONDER_BITREV_READ_EN switches playback
// to bit-reversed beat order; timing is the same in both builds.
module fft_frame_responder #(
    parameter int LANES  = 16,
    parameter int DW     = 64,
    parameter int NBEATS = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [LANES*DW-1:0]   D,
    output logic                  DONE,
    output logic [LANES*DW-1:0]   Q
);

    localparam int AW = $clog2(NBEATS);
    localparam int BW = LANES * DW;
    localparam logic [AW-1:0] LAST = AW'(NBEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        PLAY,
        TAIL,
        WAIT
    } state_t;

    state_t          state;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   rd_addr;
    logic [BW-1:0]   mem [NBEATS];

    // Reverse the bit order of a beat index across the full pointer width.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

`ifdef FFT_FRAME_RESPONDER_BITREV_READ_EN
    assign rd_addr = bitrev(rptr);
`else
    assign rd_addr = rptr;
`endif

    // Frame sequencing: capture, playback, then a fixed two-cycle turnaround.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            DONE  <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= CAPT;
                        wptr  <= '0;
                    end
                end
                CAPT: begin
                    wptr <= wptr + AW'(1);
                    if (wptr == LAST) begin
                        state <= PLAY;
                        rptr  <= '0;
                        DONE  <= 1'b1;
                    end
                end
                PLAY: begin
                    rptr <= rptr + AW'(1);
                    if (rptr == LAST) begin
                        state <= TAIL;
                        DONE  <= 1'b0;
                    end
                end
                TAIL: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

    // Frame buffer write port; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (state == CAPT) begin
            mem[wptr] <= D;
        end
    end

    // Synchronous read port registered straight onto Q; holds between frames.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (state == PLAY) begin
            Q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_fft_frame_responder.sv
// Bench for fft_frame_responder: random and patterned frames checked against
// a frame-level expectation (captured beats, playback order, window timing).
module tb_fft_frame_responder;

    localparam int LANES  = 16;
    localparam int DW     = 64;
    localparam int NBEATS = 16;
    localparam int AW     = 4;
    localparam int BW     = LANES * DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [BW-1:0] D;
    logic          DONE;
    logic [BW-1:0] Q;

    int vectors     = 0;
    int miscompares = 0;

    logic [BW-1:0] frame [NBEATS];
    logic [BW-1:0] last_q;
    bit            done_in_capt;

    fft_frame_responder #(
        .LANES  (LANES),
        .DW     (DW),
        .NBEATS (NBEATS)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .D     (D),
        .DONE  (DONE),
        .Q     (Q)
    );

    always #5 CLK = ~CLK;

    // Beat index whose data should appear for playback slot k.
    function automatic int exp_addr(input int k);
`ifdef FFT_FRAME_RESPONDER_BITREV_READ_EN
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
        return r;
`else
        return k;
`endif
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the first playback cycle (c0).
    task automatic drive_capture(input bit patterned, input bit hold);
        logic [BW-1:0] b;
        START = 1'b1;
        D = rand_beat();
        step();
        done_in_capt = 1'b0;
        for (int k = 0; k < NBEATS; k++) begin
            if (!hold) START = 1'b0;
            if (patterned) begin
                for (int i = 0; i < LANES; i++) b[i*DW +: DW] = {32'(k), 32'(i)};
            end else begin
                b = rand_beat();
            end
            frame[k] = b;
            D = b;
            done_in_capt = done_in_capt | DONE;
            step();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; D = rand_beat();
        step(); step();
        vectors++;
        if (DONE !== 1'b0) begin miscompares++; $display("FAIL reset_done actual=%b required=0", DONE); end
        vectors++;
        if (Q !== '0) begin miscompares++; $display("FAIL reset_q actual=%h required=0", Q[127:0]); end
        // reset wins over a simultaneous START
        RST = 1'b1; START = 1'b1;
        step();
        RST = 1'b0; START = 1'b0;
        for (int c = 0; c < NBEATS + 6; c++) begin
            D = rand_beat();
            step();
            vectors++;
            if (DONE !== 1'b0 || Q !== '0) begin
                miscompares++;
                $display("FAIL reset_priority cycle=%0d done=%b q=%h required done=0 q=0", c, DONE, Q[127:0]);
            end
        end
        last_q = '0;
    endtask

    task automatic test_basic(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            drive_capture(f == 0, 1'b1);
            START = 1'b0;
            vectors++;
            if (done_in_capt !== 1'b0) begin miscompares++; $display("FAIL basic_done_in_capt frame=%0d actual=1 required=0", f); end
            vectors++;
            if (DONE !== 1'b1 || Q !== last_q) begin
                miscompares++;
                $display("FAIL basic_c0 frame=%0d done=%b q=%h required done=1 q=%h", f, DONE, Q[127:0], last_q[127:0]);
            end
            for (int j = 1; j <= NBEATS; j++) begin
                step();
                vectors++;
                if (DONE !== (j < NBEATS) || Q !== frame[exp_addr(j-1)]) begin
                    miscompares++;
                    $display("FAIL basic_play frame=%0d c%0d done=%b q=%h required done=%b q=%h",
                             f, j, DONE, Q[127:0], (j < NBEATS), frame[exp_addr(j-1)][127:0]);
                end
            end
            last_q = frame[exp_addr(NBEATS-1)];
            for (int c = 0; c < 3; c++) begin
                D = rand_beat();
                step();
                vectors++;
                if (DONE !== 1'b0 || Q !== last_q) begin
                    miscompares++;
                    $display("FAIL basic_hold frame=%0d cycle=%0d done=%b q=%h required done=0 q=%h",
                             f, c, DONE, Q[127:0], last_q[127:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            drive_capture(1'b0, 1'b1);
            vectors++;
            if (DONE !== 1'b1 || Q !== last_q) begin
                miscompares++;
                $display("FAIL b2b_c0 frame=%0d done=%b q=%h required done=1 q=%h", f, DONE, Q[127:0], last_q[127:0]);
            end
            for (int j = 1; j <= NBEATS; j++) begin
                step();
                vectors++;
                if (DONE !== (j < NBEATS) || Q !== frame[exp_addr(j-1)]) begin
                    miscompares++;
                    $display("FAIL b2b_play frame=%0d c%0d done=%b q=%h required done=%b q=%h",
                             f, j, DONE, Q[127:0], (j < NBEATS), frame[exp_addr(j-1)][127:0]);
                end
            end
            last_q = frame[exp_addr(NBEATS-1)];
            if (f == 1) START = 1'b0;
            step();
            step();
            vectors++;
            if (DONE !== 1'b0 || Q !== last_q) begin
                miscompares++;
                $display("FAIL b2b_turnaround frame=%0d done=%b q=%h required done=0 q=%h", f, DONE, Q[127:0], last_q[127:0]);
            end
        end
    endtask

    task automatic test_start_drop();
        drive_capture(1'b0, 1'b0);
        vectors++;
        if (done_in_capt !== 1'b0) begin miscompares++; $display("FAIL drop_done_in_capt actual=1 required=0"); end
        vectors++;
        if (DONE !== 1'b1 || Q !== last_q) begin
            miscompares++;
            $display("FAIL drop_c0 done=%b q=%h required done=1 q=%h", DONE, Q[127:0], last_q[127:0]);
        end
        for (int j = 1; j <= NBEATS; j++) begin
            step();
            vectors++;
            if (DONE !== (j < NBEATS) || Q !== frame[exp_addr(j-1)]) begin
                miscompares++;
                $display("FAIL drop_play c%0d done=%b q=%h required done=%b q=%h",
                         j, DONE, Q[127:0], (j < NBEATS), frame[exp_addr(j-1)][127:0]);
            end
        end
        last_q = frame[exp_addr(NBEATS-1)];
        step();
        step();
    endtask

    task automatic test_reset_midframe();
        START = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            START = (k == 0) ? 1'b1 : 1'b0;
            D = rand_beat();
            step();
        end
        RST = 1'b1;
        D = rand_beat();
        step();
        vectors++;
        if (DONE !== 1'b0 || Q !== '0) begin
            miscompares++;
            $display("FAIL midreset_state done=%b q=%h required done=0 q=0", DONE, Q[127:0]);
        end
        RST = 1'b0;
        START = 1'b0;
        for (int c = 0; c < NBEATS + 6; c++) begin
            D = rand_beat();
            step();
            vectors++;
            if (DONE !== 1'b0 || Q !== '0) begin
                miscompares++;
                $display("FAIL midreset_idle cycle=%0d done=%b q=%h required done=0 q=0", c, DONE, Q[127:0]);
            end
        end
        last_q = '0;
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        D = '0;
        last_q = '0;
        test_reset();
        test_basic(3);
        test_back_to_back();
        test_start_drop();
        test_reset_midframe();
        test_start_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
